// File: rtl/processor_config_pkg.sv
// Shared configuration for the processor datapath and the byte packer that feeds it.
package processor_config;

   localparam int INP_WIDTH  = 24;
   localparam int BYTE_WIDTH = 8;

endpackage

// File: rtl/axis_byte_packer.sv
// Packs an AXI-Stream byte stream MSB-first into OUT_WIDTH-bit words for the processor,
// discarding a stale partial word after TIMEOUT_CYCLES idle cycles.
module axis_byte_packer
   import processor_config::*;
#(
   parameter int OUT_WIDTH      = INP_WIDTH,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   output logic [OUT_WIDTH-1:0] m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 timeout_drop
);

   localparam int NB    = OUT_WIDTH / BYTE_WIDTH;
   localparam int CW    = (NB > 1) ? $clog2(NB) : 1;
   localparam int AW    = (NB > 1) ? (NB - 1) * BYTE_WIDTH : BYTE_WIDTH;
   localparam int IW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int TO_M1 = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   localparam logic [CW-1:0] LAST_IDX   = CW'(NB - 1);
   localparam logic [IW-1:0] IDLE_LIMIT = IW'(TO_M1);

   logic [CW-1:0]        byte_cnt;
   logic [IW-1:0]        idle_cnt;
   logic [OUT_WIDTH-1:0] full_word;
   logic                 last_byte;
   logic                 accept;
   logic                 drain;
   logic                 idle_run;
   logic                 expire;

   // The final byte may only enter when the output register is free or draining this cycle.
   always_comb begin
      last_byte     = (byte_cnt == LAST_IDX);
      s_axis_tready = !rst && (!last_byte || !m_axis_tvalid || m_axis_tready);
      accept        = s_axis_tvalid && s_axis_tready;
      drain         = m_axis_tvalid && m_axis_tready;
      idle_run      = (TIMEOUT_CYCLES != 0) && (byte_cnt != '0) && !s_axis_tvalid;
      expire        = idle_run && (idle_cnt == IDLE_LIMIT);
   end

   generate
      if (NB > 1) begin : g_pack
         logic [AW-1:0] asm_reg;
         logic [AW-1:0] asm_next;

         always_comb begin
            asm_next                   = asm_reg << BYTE_WIDTH;
            asm_next[BYTE_WIDTH-1:0]   = s_axis_tdata;
            full_word                  = {asm_reg, s_axis_tdata};
         end

         // Earlier bytes shift toward the MSB end; stale bytes after a drop are shifted out.
         always_ff @(posedge clk) begin
            if (rst) begin
               asm_reg <= '0;
            end else if (accept) begin
               asm_reg <= asm_next;
            end
         end
      end else begin : g_slice
         always_comb begin
            full_word = s_axis_tdata;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt      <= '0;
         idle_cnt      <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         timeout_drop  <= 1'b0;
      end else begin
         timeout_drop <= expire;

         if (accept) begin
            idle_cnt <= '0;
            byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
         end else if (expire) begin
            byte_cnt <= '0;
            idle_cnt <= '0;
         end else if (idle_run) begin
            idle_cnt <= idle_cnt + 1'b1;
         end else if (byte_cnt == '0) begin
            idle_cnt <= '0;
         end

         // A load in the drain cycle keeps tvalid high with the new word.
         if (accept && last_byte) begin
            m_axis_tdata  <= full_word;
            m_axis_tvalid <= 1'b1;
         end else if (drain) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Bench for axis_byte_packer: directed scenarios on a 24-bit/timeout-4 instance and
// randomized scoreboard runs on that instance and on an 8-bit register-slice instance.
module tb_axis_byte_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [7:0]  a_data   = '0;
   logic        a_valid  = 1'b0;
   logic        a_sready;
   logic [23:0] a_mdata;
   logic        a_mvalid;
   logic        a_mready = 1'b0;
   logic        a_drop;

   logic [7:0]  b_data   = '0;
   logic        b_valid  = 1'b0;
   logic        b_sready;
   logic [7:0]  b_mdata;
   logic        b_mvalid;
   logic        b_mready = 1'b0;
   logic        b_drop;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axis_byte_packer #(.OUT_WIDTH(24), .TIMEOUT_CYCLES(4)) dut_a (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (a_data),
      .s_axis_tvalid (a_valid),
      .s_axis_tready (a_sready),
      .m_axis_tdata  (a_mdata),
      .m_axis_tvalid (a_mvalid),
      .m_axis_tready (a_mready),
      .timeout_drop  (a_drop)
   );

   axis_byte_packer #(.OUT_WIDTH(8)) dut_b (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (b_data),
      .s_axis_tvalid (b_valid),
      .s_axis_tready (b_sready),
      .m_axis_tdata  (b_mdata),
      .m_axis_tvalid (b_mvalid),
      .m_axis_tready (b_mready),
      .timeout_drop  (b_drop)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle on instance A from the falling edge, then let outputs settle.
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
      @(negedge clk);
      a_valid  = v;
      a_data   = d;
      a_mready = r;
      #1;
   endtask

   initial begin : main
      logic [7:0]  q[$];
      logic [31:0] exp_word;
      logic [23:0] held;
      int          drops;
      int          sent;
      int          words;
      int          cyc;
      bit          pend;
      bit          prev_low;
      bit          stall_prev;

      // Reset behaviour
      @(negedge clk);
      #1;
      checkOutput("rst_a_tready", a_sready, 0);
      checkOutput("rst_b_tready", b_sready, 0);
      checkOutput("rst_a_tvalid", a_mvalid, 0);
      checkOutput("rst_a_tdata", a_mdata, 0);
      checkOutput("rst_a_drop", a_drop, 0);
      checkOutput("rst_b_tvalid", b_mvalid, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("post_rst_a_tready", a_sready, 1);
      checkOutput("post_rst_b_tready", b_sready, 1);

      // Three bytes in consecutive cycles, one-cycle latency to the packed word
      applyStimulus(1, 8'hA1, 1);
      applyStimulus(1, 8'hB2, 1);
      applyStimulus(1, 8'hC3, 1);
      checkOutput("basic_tready_last", a_sready, 1);
      checkOutput("basic_tvalid_early", a_mvalid, 0);
      applyStimulus(0, 8'h00, 1);
      checkOutput("basic_tvalid", a_mvalid, 1);
      checkOutput("basic_tdata", a_mdata, 32'hA1B2C3);
      applyStimulus(0, 8'h00, 1);
      checkOutput("basic_tvalid_clear", a_mvalid, 0);

      // Back-to-back words against a stalled output
      applyStimulus(1, 8'h01, 0);
      applyStimulus(1, 8'h02, 0);
      applyStimulus(1, 8'h03, 0);
      applyStimulus(1, 8'h04, 0);
      checkOutput("stall_tvalid", a_mvalid, 1);
      checkOutput("stall_tdata", a_mdata, 32'h010203);
      checkOutput("stall_tready_b4", a_sready, 1);
      applyStimulus(1, 8'h05, 0);
      checkOutput("stall_tready_b5", a_sready, 1);
      applyStimulus(1, 8'h06, 0);
      checkOutput("stall_tready_b6", a_sready, 0);
      applyStimulus(1, 8'h06, 0);
      checkOutput("stall_tready_b6_again", a_sready, 0);
      checkOutput("stall_hold_data", a_mdata, 32'h010203);
      applyStimulus(1, 8'h06, 1);
      checkOutput("stall_release_tready", a_sready, 1);
      checkOutput("stall_release_data", a_mdata, 32'h010203);
      applyStimulus(0, 8'h00, 1);
      checkOutput("stall_second_tvalid", a_mvalid, 1);
      checkOutput("stall_second_tdata", a_mdata, 32'h040506);
      applyStimulus(0, 8'h00, 1);
      checkOutput("stall_drained", a_mvalid, 0);

      // Timeout after four idle cycles discards the partial word
      drops = 0;
      applyStimulus(1, 8'h11, 1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 8'h00, 1);
         drops += int'(a_drop);
      end
      checkOutput("to_no_early_drop", drops, 0);
      applyStimulus(1, 8'h22, 1);
      checkOutput("to_drop_pulse", a_drop, 1);
      applyStimulus(1, 8'h33, 1);
      checkOutput("to_drop_one_cycle", a_drop, 0);
      applyStimulus(1, 8'h44, 1);
      applyStimulus(0, 8'h00, 1);
      checkOutput("to_word_valid", a_mvalid, 1);
      checkOutput("to_word_data", a_mdata, 32'h223344);

      // A byte arriving in the would-be timeout cycle wins
      drops = 0;
      applyStimulus(1, 8'h11, 1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 8'h00, 1);
         drops += int'(a_drop);
      end
      applyStimulus(1, 8'h22, 1);
      drops += int'(a_drop);
      applyStimulus(1, 8'h33, 1);
      drops += int'(a_drop);
      applyStimulus(0, 8'h00, 1);
      drops += int'(a_drop);
      checkOutput("race_word_valid", a_mvalid, 1);
      checkOutput("race_word_data", a_mdata, 32'h112233);
      applyStimulus(0, 8'h00, 1);
      drops += int'(a_drop);
      checkOutput("race_no_drop", drops, 0);

      // Reset with a stalled word and a partial word in flight
      applyStimulus(1, 8'h01, 0);
      applyStimulus(1, 8'h02, 0);
      applyStimulus(1, 8'h03, 0);
      applyStimulus(1, 8'h04, 0);
      applyStimulus(1, 8'h05, 0);
      checkOutput("mid_rst_pending", a_mvalid, 1);
      @(negedge clk);
      rst     = 1'b1;
      a_valid = 1'b0;
      #1;
      checkOutput("mid_rst_tready", a_sready, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("mid_rst_tvalid", a_mvalid, 0);
      applyStimulus(1, 8'h07, 1);
      applyStimulus(1, 8'h08, 1);
      applyStimulus(1, 8'h09, 1);
      applyStimulus(0, 8'h00, 1);
      checkOutput("mid_rst_clean_valid", a_mvalid, 1);
      checkOutput("mid_rst_clean_data", a_mdata, 32'h070809);
      applyStimulus(0, 8'h00, 1);

      // Randomized 24-bit run; idle gaps never exceed one cycle so no timeout can fire
      q.delete();
      sent = 0; words = 0; cyc = 0;
      pend = 0; prev_low = 0; stall_prev = 0; held = '0;
      while (words < 100 && cyc < 4000) begin
         cyc++;
         @(negedge clk);
         if (stall_prev) begin
            checkOutput("a_hold_valid", a_mvalid, 1);
            checkOutput("a_hold_data", a_mdata, held);
         end
         if (!pend) begin
            if (sent < 300) begin
               a_valid = prev_low ? 1'b1 : 1'($urandom_range(0, 1));
               if (a_valid) a_data = 8'($urandom);
            end else begin
               a_valid = 1'b0;
            end
         end
         prev_low = !a_valid;
         a_mready = 1'($urandom_range(0, 1));
         #1;
         if (a_valid && a_sready) begin
            q.push_back(a_data);
            sent++;
            pend = 0;
         end else begin
            pend = a_valid;
         end
         if (a_mvalid && a_mready) begin
            checkOutput("a_word_avail", q.size() >= 3, 1);
            if (q.size() >= 3) begin
               exp_word = {8'h00, q[0], q[1], q[2]};
               void'(q.pop_front());
               void'(q.pop_front());
               void'(q.pop_front());
               checkOutput("a_word", a_mdata, exp_word);
            end
            words++;
         end
         checkOutput("a_no_drop", a_drop, 0);
         stall_prev = a_mvalid && !a_mready;
         held       = a_mdata;
      end
      checkOutput("a_word_count", words, 100);
      applyStimulus(0, 8'h00, 1);

      // Randomized register-slice run: output must equal input exactly
      q.delete();
      sent = 0; words = 0; cyc = 0; pend = 0;
      while (words < 1000 && cyc < 20000) begin
         cyc++;
         @(negedge clk);
         if (!pend) begin
            b_valid = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (b_valid) b_data = 8'($urandom);
         end
         b_mready = 1'($urandom_range(0, 1));
         #1;
         if (b_valid && b_sready) begin
            q.push_back(b_data);
            sent++;
            pend = 0;
         end else begin
            pend = b_valid;
         end
         if (b_mvalid && b_mready) begin
            checkOutput("b_byte_avail", q.size() >= 1, 1);
            if (q.size() >= 1) begin
               exp_word = {24'h0, q[0]};
               void'(q.pop_front());
               checkOutput("b_byte", b_mdata, exp_word);
            end
            words++;
         end
      end
      checkOutput("b_byte_count", words, 1000);
      checkOutput("b_queue_empty", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
